// File: rtl/rams_sp_3d_ctl.sv
// Multi-bank single-port RAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register and a clear sequencer that zeroes every bank.
module rams_sp_3d_ctl #(
  parameter int NUM_RAMS   = 4,
  parameter int A_WID      = 10,
  parameter int D_WID      = 32,
  parameter int BYTE_WID   = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_RAMS-1:0]                      ena,
  input  logic [NUM_RAMS-1:0][D_WID/BYTE_WID-1:0]  we,
  input  logic [A_WID-1:0]                         addr [NUM_RAMS],
  input  logic [D_WID-1:0]                         din  [NUM_RAMS],
  input  logic                                     init_start,
  output logic [D_WID-1:0]                         dout [NUM_RAMS],
  output logic [NUM_RAMS-1:0]                      dout_valid,
  output logic                                     init_busy
);

  localparam int unsigned NB    = D_WID / BYTE_WID;
  localparam int unsigned DEPTH = 2 ** A_WID;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e           state_q, state_d;
  logic [A_WID-1:0] cnt_q, cnt_d;
  logic             clr_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // cnt wraps back to zero on the last address, ready for the next clear
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    init_busy = (state_q != IDLE);
    clr_we    = (state_q == CLEAR);
  end

  for (genvar i = 0; i < NUM_RAMS; i++) begin : g_bank
    logic [D_WID-1:0] mem [DEPTH];
    logic [D_WID-1:0] old_w, new_w;
    logic [D_WID-1:0] rd1_q, rd1_d;
    logic             v1_q, v1_d;
    logic             acc, wr;

    always_comb begin
      old_w = mem[addr[i]];
      new_w = old_w;
      for (int unsigned b = 0; b < NB; b++) begin
        if (we[i][b]) new_w[b*BYTE_WID +: BYTE_WID] = din[i][b*BYTE_WID +: BYTE_WID];
      end
      acc   = ena[i] && !init_busy;
      wr    = acc && (|we[i]);
      rd1_d = rd1_q;
      v1_d  = 1'b0;
      if (acc) begin
        if (RD_MODE == 1) begin
          rd1_d = new_w;
          v1_d  = 1'b1;
        end else if (RD_MODE == 2 && (|we[i])) begin
          // no-change: a write leaves the read register untouched
          rd1_d = rd1_q;
        end else begin
          rd1_d = old_w;
          v1_d  = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (clr_we)  mem[cnt_q]   <= '0;
      else if (wr) mem[addr[i]] <= new_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd1_q <= '0;
        v1_q  <= 1'b0;
      end else begin
        rd1_q <= rd1_d;
        v1_q  <= v1_d;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic [D_WID-1:0] dout_q, dout_d;
      logic             vld_q, vld_d;

      always_comb begin
        dout_d = v1_q ? rd1_q : dout_q;
        vld_d  = v1_q;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          dout_q <= dout_d;
          vld_q  <= vld_d;
        end
      end

      assign dout[i]       = dout_q;
      assign dout_valid[i] = vld_q;
    end else begin : g_nooreg
      assign dout[i]       = rd1_q;
      assign dout_valid[i] = v1_q;
    end
  end

endmodule

// File: doc/rams_sp_3d_ctl.md
# rams_sp_3d_ctl

Parametrised multi-bank single-port RAM and successor to the basic 3-D single-port array. It adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline stage with valid tracking, and a hardware clear sequencer that zeroes every bank after reset or on request. It sits between the datapath engines and the block-RAM fabric, with one independent port per bank.

## Interface
- NUM_RAMS, 4, number of independent banks (1..16)
- A_WID, 10, address width per bank; depth = 2**A_WID
- D_WID, 32, data width; must be a multiple of BYTE_WID
- BYTE_WID, 8, byte-lane width; NB = D_WID/BYTE_WID lanes
- RD_MODE, 0, read-during-write: 0 read-first, 1 write-first, 2 no-change
- OUT_REG, 1, 0 = dout one cycle after access; 1 = extra output register stage
- INIT_CLEAR, 1, 1 = clear all banks automatically when reset is released
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  NUM_RAMS  per-bank access enable
- we  in  [NUM_RAMS-1:0][NB-1:0]  per-bank, per-byte write enable; qualified by ena
- addr  in  A_WID x NUM_RAMS (unpacked)  per-bank address
- din  in  D_WID x NUM_RAMS (unpacked)  per-bank write data
- init_start  in  1  pulse; starts a clear when the sequencer is IDLE
- dout  out  D_WID x NUM_RAMS (unpacked)  per-bank read data
- dout_valid  out  NUM_RAMS  per-bank read-data valid
- init_busy  out  1  high while the clear sequencer owns all banks

## Operation
- **Bank access (init_busy=0, ena[i]=1).**
  - Each byte lane b with we[i][b]=1 writes din[i] lane b into mem[i][addr[i]].
  - Lanes with we=0 keep their stored value.
- **Read data per RD_MODE, captured in stage-1 register rd1[i]:**
  - Mode 0: pre-write word.
  - Mode 1: post-write merged word (written lanes from din, the rest from memory).
  - Mode 2: if any we[i] bit is set, rd1[i] holds its value and no valid is generated; otherwise the stored word.
- **Pure read (all we[i]=0).** Identical result in all modes.
- **ena[i]=0.** No memory change; rd1[i] and dout[i] hold; no valid is generated.
- **Clear sequencer FSM.**
  - States: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on init_start=1.
  - CLEAR: counter cnt runs 0 .. 2**A_WID-1. Each cycle writes zero to mem[*][cnt] in every bank, all lanes.
  - CLEAR -> DONE after cnt = 2**A_WID-1 is written.
  - DONE -> IDLE unconditionally after one cycle.
  - init_busy = 1 in CLEAR and DONE.
  - While init_busy=1: ena, we and init_start are ignored, and no dout_valid is generated.
  - init_start while busy is dropped, not queued.
- **Reset.**
  - FSM enters CLEAR if INIT_CLEAR=1, otherwise IDLE.
  - cnt = 0.
  - Memory contents are not reset.
- **Reset asserted mid-clear.** Sequence aborts; it restarts from address 0 after release (INIT_CLEAR=1) or stays IDLE (INIT_CLEAR=0).

## Timing
- **Reset values:**
  - dout = 0 for all banks
  - dout_valid = 0
  - rd1 = 0
  - init_busy = INIT_CLEAR
  - cnt = 0
- **Read latency (ena sampled at edge N):**
  - OUT_REG=0: dout/dout_valid update after edge N.
  - OUT_REG=1: update after edge N+1.
  - Throughput is one access per bank per cycle in both cases.
- **dout_valid[i].**
  - Pulses one cycle per qualifying access, aligned with dout.
  - When low, dout holds its last value.
- **Clear duration.**
  - init_busy high for exactly 2**A_WID + 1 cycles: CLEAR plus one DONE cycle.
  - The first user access is accepted on the edge where init_busy is sampled 0.
  - With INIT_CLEAR=1, init_busy is already 1 out of reset and stays 1 for those cycles after the first clock edge following release.
- **Write visibility.** A write at edge N is visible to a read at edge N+1, or the same edge in mode 1.
- **Bank independence.** Banks are fully independent; simultaneous identical addresses across banks carry no interaction.

## Test plan
- **Reset/clear.** A_WID=4, INIT_CLEAR=1; release rst_n -> init_busy=1 for 17 cycles; then read all 16 addresses of every bank -> dout=0, dout_valid asserted 2 cycles after each ena (OUT_REG=1).
- **Byte-lane write.** Bank 1, addr 5: write 0xAABBCCDD with we=4'b1111, then 0x11223344 with we=4'b0101; read -> 0xAA22CC44. Bank 0 addr 5 still reads 0.
- **Read-during-write.** Addr 3 holds 0x12345678; write 0xFFFFFFFF, we=4'b0011:
  - RD_MODE=0 -> dout=0x12345678.
  - RD_MODE=1 -> dout=0x1234FFFF.
  - RD_MODE=2 -> dout holds previous value, dout_valid=0.
- **Latency and back-to-back reads.** OUT_REG=0 vs 1, reads to addrs 0,1,2 on consecutive cycles -> valid data arrives 1 vs 2 cycles later, one word per cycle, no gaps.
- **Re-clear and busy gating.** After traffic, pulse init_start; a second pulse plus ena/we during busy is ignored; after busy drops, all data reads 0 and init_busy does not reassert.
- **Reset mid-clear.** Assert rst_n=0 at cnt=7, hold 3 cycles -> dout/dout_valid go 0 immediately; after release the clear restarts from addr 0 and init_busy lasts a full 17 cycles.
